tbuart_rx: RTL and testbench

//  Synthesizable 8N1 UART receive monitor for the UART pin of the chip top (mprj_io[6]).

---
 rtl/tbuart_rx_pkg.sv | 19 +
 rtl/tbuart_sync2.sv | 25 ++
 rtl/tbuart_rx.sv | 124 ++++++++++++
 tb/tb_tbuart_rx.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tbuart_rx_pkg.sv
// Shared definitions for the tbuart_rx UART receive monitor.
// FSM encoding, line terminator and the line-length counter step.
package tbuart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Saturating increment used by the per-line byte counter
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tbuart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line.
// Resets to 1 so a line held in reset reads as idle.
module tbuart_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/tbuart_rx.sv
// 8N1 UART receive monitor: recovers bytes, flags framing errors and
// counts bytes per text line (terminated by LF) for print-output detection.
module tbuart_rx
  import tbuart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned MAX_LINE     = 255
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       ser_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy,
  output logic       line_done,
  output logic [7:0] char_count
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TW-1:0]   r_timer;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shreg;
  logic            r_wait_high;
  logic [7:0]      r_rx_data;
  logic            r_rx_valid;
  logic            r_frame_err;
  logic            r_busy;
  logic            r_line_done;
  logic [7:0]      r_char_count;
  logic            w_rx_s;
  logic            w_tick_half;
  logic            w_tick_full;

  tbuart_sync2 u_sync (
    .i_clk   (clock),
    .i_rst_n (resetb),
    .i_d     (ser_rx),
    .o_q     (w_rx_s)
  );

  assign w_tick_half = (r_timer == HALF_M1);
  assign w_tick_full = (r_timer == FULL_M1);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (!r_wait_high && !w_rx_s) w_state_nxt = START;
      START: if (w_tick_half) w_state_nxt = w_rx_s ? IDLE : DATA;
      DATA:  if (w_tick_full && (r_bit_idx == 3'd7)) w_state_nxt = STOP;
      STOP:  if (w_tick_full) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bit timing, shifting and registered result pulses
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_timer      <= '0;
      r_bit_idx    <= 3'd0;
      r_shreg      <= 8'd0;
      r_wait_high  <= 1'b0;
      r_rx_data    <= 8'd0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
      r_line_done  <= 1'b0;
      r_char_count <= 8'd0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_line_done <= 1'b0;
      r_busy      <= (w_state_nxt != IDLE);

      if ((r_state == IDLE) || ((r_state == START) && w_tick_half)) r_timer <= '0;
      else if (w_tick_full)                                       r_timer <= '0;
      else                                                        r_timer <= r_timer + TW'(1);

      if (r_state == START) r_bit_idx <= 3'd0;

      if ((r_state == DATA) && w_tick_full) begin
        r_shreg   <= {w_rx_s, r_shreg[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end

      // A low stop bit may be a break; hold off new frames until the line idles
      if ((r_state == IDLE) && w_rx_s) r_wait_high <= 1'b0;

      if ((r_state == STOP) && w_tick_full) begin
        if (w_rx_s) begin
          r_rx_data  <= r_shreg;
          r_rx_valid <= 1'b1;
          if (r_shreg == ASCII_LF) begin
            r_line_done  <= 1'b1;
            r_char_count <= 8'd0;
          end else begin
            r_char_count <= sat_inc(r_char_count, 8'(MAX_LINE));
          end
        end else begin
          r_frame_err <= 1'b1;
          r_wait_high <= 1'b1;
        end
      end
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;
  assign line_done  = r_line_done;
  assign char_count = r_char_count;

endmodule

// File: tb/tb_tbuart_rx.sv
// Directed bench for tbuart_rx at 16 clocks per bit.
module tb_tbuart_rx;

  localparam int unsigned CPB = 16;

  logic       clock = 1'b0;
  logic       resetb;
  logic       ser_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;
  logic       line_done;
  logic [7:0] char_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_fall = 0;

  logic [7:0] q_data[$];
  logic [7:0] q_cc[$];
  logic       q_ld[$];
  int         q_cyc[$];
  int         n_ferr = 0;
  int         n_ld = 0;
  int         n_both = 0;

  tbuart_rx #(.CLKS_PER_BIT(CPB), .MAX_LINE(255)) dut (
    .clock      (clock),
    .resetb     (resetb),
    .ser_rx     (ser_rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .busy       (busy),
    .line_done  (line_done),
    .char_count (char_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Record every pulse for later inspection by the scenario tasks
  always @(negedge clock) begin
    if (rx_valid) begin
      q_data.push_back(rx_data);
      q_cc.push_back(char_count);
      q_ld.push_back(line_done);
      q_cyc.push_back(cyc);
    end
    if (frame_err) n_ferr++;
    if (line_done) n_ld++;
    if (rx_valid && frame_err) n_both++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    ser_rx = 1'b0;
    last_fall = cyc;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      ser_rx = d[i];
      tick(CPB);
    end
    ser_rx = stop_b;
    tick(CPB);
    if (stop_b) ser_rx = 1'b1;
  endtask

  task automatic test_reset;
    resetb = 1'b0;
    ser_rx = 1'b1;
    tick(3);
    n_cmp++;
    if ({rx_data, rx_valid, frame_err, busy, line_done, char_count} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_outputs got %h want %h",
               {rx_data, rx_valid, frame_err, busy, line_done, char_count}, 20'h0);
    end
    resetb = 1'b1;
    tick(5);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle_busy got %b want 0", busy);
    end
  endtask

  task automatic test_line;
    int base;
    int ld0;
    int fe0;
    logic [7:0] exp_d [3];
    logic [7:0] exp_c [3];
    logic       exp_l [3];
    exp_d = '{8'h4F, 8'h4B, 8'h0A};
    exp_c = '{8'd1, 8'd2, 8'd0};
    exp_l = '{1'b0, 1'b0, 1'b1};
    base = q_data.size();
    ld0 = n_ld;
    fe0 = n_ferr;
    for (int i = 0; i < 3; i++) send_frame(exp_d[i], 1'b1);
    tick(20);
    n_cmp++;
    if (q_data.size() - base !== 3) begin
      n_bad++;
      $display("FAIL line_valid_count got %0d want 3", q_data.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if ({q_data[base+i], q_cc[base+i], q_ld[base+i]} !== {exp_d[i], exp_c[i], exp_l[i]}) begin
          n_bad++;
          $display("FAIL line_byte%0d got data=%h cc=%0d ld=%b want data=%h cc=%0d ld=%b", i,
                   q_data[base+i], q_cc[base+i], q_ld[base+i], exp_d[i], exp_c[i], exp_l[i]);
        end
      end
    end
    n_cmp++;
    if ((n_ld - ld0 !== 1) || (n_ferr - fe0 !== 0)) begin
      n_bad++;
      $display("FAIL line_pulses got ld=%0d fe=%0d want ld=1 fe=0", n_ld - ld0, n_ferr - fe0);
    end
  endtask

  task automatic test_single;
    int base;
    int fe0;
    base = q_data.size();
    fe0 = n_ferr;
    send_frame(8'h41, 1'b1);
    tick(20);
    n_cmp++;
    if (q_data.size() - base !== 1) begin
      n_bad++;
      $display("FAIL single_valid_count got %0d want 1", q_data.size() - base);
    end else begin
      n_cmp++;
      if (q_data[base] !== 8'h41) begin
        n_bad++;
        $display("FAIL single_data got %h want 41", q_data[base]);
      end
      n_cmp++;
      if (q_cyc[base] - last_fall !== 155) begin
        n_bad++;
        $display("FAIL single_latency got %0d want 155", q_cyc[base] - last_fall);
      end
    end
    n_cmp++;
    if ({rx_data, char_count} !== {8'h41, 8'd1}) begin
      n_bad++;
      $display("FAIL single_hold got data=%h cc=%0d want data=41 cc=1", rx_data, char_count);
    end
    n_cmp++;
    if (n_ferr - fe0 !== 0) begin
      n_bad++;
      $display("FAIL single_frame_err got %0d want 0", n_ferr - fe0);
    end
  endtask

  task automatic test_glitch;
    int base;
    int fe0;
    base = q_data.size();
    fe0 = n_ferr;
    ser_rx = 1'b0;
    tick(4);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL glitch_busy_set got %b want 1", busy);
    end
    tick(1);
    ser_rx = 1'b1;
    tick(12);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_busy_clear got %b want 0", busy);
    end
    tick(200);
    n_cmp++;
    if ((q_data.size() - base !== 0) || (n_ferr - fe0 !== 0)) begin
      n_bad++;
      $display("FAIL glitch_pulses got valid=%0d fe=%0d want 0 0", q_data.size() - base, n_ferr - fe0);
    end
  endtask

  task automatic test_frame_err;
    int base;
    int fe0;
    base = q_data.size();
    fe0 = n_ferr;
    send_frame(8'h55, 1'b0);
    tick(40);
    n_cmp++;
    if ((n_ferr - fe0 !== 1) || (q_data.size() - base !== 0)) begin
      n_bad++;
      $display("FAIL ferr_pulses got fe=%0d valid=%0d want fe=1 valid=0", n_ferr - fe0, q_data.size() - base);
    end
    n_cmp++;
    if ({rx_data, char_count, busy} !== {8'h41, 8'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL ferr_hold got data=%h cc=%0d busy=%b want data=41 cc=1 busy=0", rx_data, char_count, busy);
    end
    ser_rx = 1'b1;
    tick(20);
    n_cmp++;
    if (n_ferr - fe0 !== 1) begin
      n_bad++;
      $display("FAIL ferr_no_retrigger got fe=%0d want 1", n_ferr - fe0);
    end
    send_frame(8'h5A, 1'b1);
    tick(20);
    n_cmp++;
    if ({rx_data, char_count} !== {8'h5A, 8'd2}) begin
      n_bad++;
      $display("FAIL ferr_recover got data=%h cc=%0d want data=5a cc=2", rx_data, char_count);
    end
  endtask

  task automatic test_reset_mid;
    int base;
    int fe0;
    logic [7:0] d;
    d = 8'hA5;
    base = q_data.size();
    fe0 = n_ferr;
    ser_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      ser_rx = d[i];
      tick(CPB);
    end
    ser_rx = d[4];
    tick(CPB / 2);
    resetb = 1'b0;
    tick(2);
    n_cmp++;
    if ({rx_data, rx_valid, frame_err, busy, line_done, char_count} !== 20'h0) begin
      n_bad++;
      $display("FAIL midreset_outputs got %h want %h",
               {rx_data, rx_valid, frame_err, busy, line_done, char_count}, 20'h0);
    end
    ser_rx = 1'b1;
    tick(3);
    resetb = 1'b1;
    tick(CPB * 12);
    n_cmp++;
    if ((q_data.size() - base !== 0) || (n_ferr - fe0 !== 0) || (busy !== 1'b0)) begin
      n_bad++;
      $display("FAIL midreset_silent got valid=%0d fe=%0d busy=%b want 0 0 0",
               q_data.size() - base, n_ferr - fe0, busy);
    end
    send_frame(8'h3C, 1'b1);
    tick(20);
    n_cmp++;
    if ((q_data.size() - base !== 1) || ({rx_data, char_count} !== {8'h3C, 8'd1})) begin
      n_bad++;
      $display("FAIL midreset_next got valid=%0d data=%h cc=%0d want valid=1 data=3c cc=1",
               q_data.size() - base, rx_data, char_count);
    end
  endtask

  task automatic test_saturation;
    int base;
    int ld0;
    int exp_cc;
    logic [7:0] b;
    base = q_data.size();
    for (int i = 0; i < 300; i++) begin
      b = 8'h61 + 8'(i % 26);
      send_frame(b, 1'b1);
    end
    tick(10);
    n_cmp++;
    if (q_data.size() - base !== 300) begin
      n_bad++;
      $display("FAIL sat_valid_count got %0d want 300", q_data.size() - base);
    end else begin
      // char_count starts at 1 from the previous scenario
      for (int i = 252; i < 300; i += 47) begin
        exp_cc = (i + 2 > 255) ? 255 : i + 2;
        n_cmp++;
        if (q_cc[base+i] !== 8'(exp_cc)) begin
          n_bad++;
          $display("FAIL sat_cc_byte%0d got %0d want %0d", i, q_cc[base+i], exp_cc);
        end
      end
      n_cmp++;
      if (q_cc[base+253] !== 8'd255) begin
        n_bad++;
        $display("FAIL sat_cc_reach got %0d want 255", q_cc[base+253]);
      end
    end
    n_cmp++;
    if ({rx_data, char_count} !== {8'h61 + 8'(299 % 26), 8'd255}) begin
      n_bad++;
      $display("FAIL sat_hold got data=%h cc=%0d want data=%h cc=255", rx_data, char_count, 8'h61 + 8'(299 % 26));
    end
    ld0 = n_ld;
    send_frame(8'h0A, 1'b1);
    tick(20);
    n_cmp++;
    if ((n_ld - ld0 !== 1) || (char_count !== 8'd0) || (rx_data !== 8'h0A)) begin
      n_bad++;
      $display("FAIL sat_lf got ld=%0d cc=%0d data=%h want ld=1 cc=0 data=0a", n_ld - ld0, char_count, rx_data);
    end
  endtask

  initial begin
    resetb = 1'b0;
    ser_rx = 1'b1;
    tick(2);
    test_reset();
    test_line();
    test_single();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_saturation();
    n_cmp++;
    if (n_both !== 0) begin
      n_bad++;
      $display("FAIL valid_and_ferr_overlap got %0d want 0", n_both);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
